// File: rtl/axi_lite_reg_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
package axi_lite_reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] data,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank slave with per-register write pulses.
// Optional AXI_LITE_REG_SLAVE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axi_lite_reg_slave
    import axi_lite_reg_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_W-1:0]            AWADDR,
    input  logic [2:0]                   AWPROT,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_W-1:0]            WDATA,
    input  logic [DATA_W/8-1:0]          WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [2:0]                   ARPROT,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_W-1:0]            RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    output logic [NUM_REGS*DATA_W-1:0]   reg_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o,
    output wr_state_t                    wr_state_o
);

    localparam int IDX_W = ADDR_W - 2;

`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    // Valid/ready: a transfer happens on any ACLK edge where both are 1; all readies/valids are registered.
    wr_state_t               state_q, state_d;
    logic                    awready_q, awready_d, wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [IDX_W-1:0]        widx_q, widx_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W/8-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];
    logic [DATA_W-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_pulse_q, wr_pulse_d;
    logic                    arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0]        aw_idx, ar_idx;
    logic                    unused_ok;

    assign aw_idx    = AWADDR[ADDR_W-1:2];
    assign ar_idx    = ARADDR[ADDR_W-1:2];
    assign aw_hs     = AWVALID && awready_q;
    assign w_hs      = WVALID && wready_q;
    assign ar_hs     = ARVALID && arready_q;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (aw_hs) widx_d = aw_idx;
        if (w_hs) begin
            wdata_d = WDATA;
            wstrb_d = WSTRB;
        end
        case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) state_d = WR_COMMIT;
                else if (aw_hs)    state_d = WR_HAVE_AW;
                else if (w_hs)     state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs) state_d = WR_COMMIT;
            WR_HAVE_W:  if (aw_hs) state_d = WR_COMMIT;
            WR_COMMIT: begin
                // An index matching no register falls through: no update, no pulse, OOR response.
                bvalid_d = 1'b1;
                bresp_d  = OOR_RESP;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (widx_q == IDX_W'(i)) begin
                        regs_d[i]     = byte_merge(regs_q[i], wdata_q, wstrb_q);
                        wr_pulse_d[i] = 1'b1;
                        bresp_d       = RESP_OKAY;
                    end
                end
                state_d = WR_RESP;
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_d = 1'b0;
                    state_d  = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
        awready_d = (state_d == WR_IDLE) || (state_d == WR_HAVE_W);
        wready_d  = (state_d == WR_IDLE) || (state_d == WR_HAVE_AW);
    end

    // Reads sample regs_q, so a commit on the same edge as the AR handshake is not seen.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = OOR_RESP;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (ar_idx == IDX_W'(i)) begin
                    rdata_d = regs_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
        end
        // Holding off while rvalid_q is set inserts the bubble in the cycle RVALID drops.
        arready_d = !rvalid_q && !rvalid_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            widx_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_o
        assign reg_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

    assign AWREADY    = awready_q;
    assign WREADY     = wready_q;
    assign BVALID     = bvalid_q;
    assign BRESP      = bresp_q;
    assign ARREADY    = arready_q;
    assign RVALID     = rvalid_q;
    assign RDATA      = rdata_q;
    assign RRESP      = rresp_q;
    assign wr_pulse_o = wr_pulse_q;
    assign wr_state_o = state_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave; expectations are hand-computed constants.
module tb_axi_lite_reg_slave;
    import axi_lite_reg_pkg::*;

    localparam int NUM_REGS = 4;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 32;

`ifdef AXI_LITE_REG_SLAVE_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic                       ACLK = 1'b0;
    logic                       ARESETN;
    logic [ADDR_W-1:0]          AWADDR, ARADDR;
    logic [2:0]                 AWPROT, ARPROT;
    logic                       AWVALID, WVALID, BREADY, ARVALID, RREADY;
    logic                       AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [DATA_W-1:0]          WDATA, RDATA;
    logic [DATA_W/8-1:0]        WSTRB;
    logic [1:0]                 BRESP, RRESP;
    logic [NUM_REGS*DATA_W-1:0] reg_o;
    logic [NUM_REGS-1:0]        wr_pulse_o;
    wr_state_t                  wr_state_o;

    int checks = 0;
    int errors = 0;
    logic [NUM_REGS-1:0] exp_q[$];
    logic [NUM_REGS*DATA_W-1:0] last_reg_o;
    bit aw_wait_ok;

    axi_lite_reg_slave #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_o(reg_o), .wr_pulse_o(wr_pulse_o), .wr_state_o(wr_state_o)
    );

    // Clock and watchdog
    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse scoreboard: every non-zero wr_pulse_o cycle must match the next expected vector.
    always @(posedge ACLK) begin
        #1;
        if (ARESETN && wr_pulse_o != '0) begin
            if (exp_q.size() == 0) check("wr_pulse_unexpected", 64'(wr_pulse_o), 64'h0);
            else check("wr_pulse", 64'(wr_pulse_o), 64'(exp_q.pop_front()));
        end
    end

    // Drivers: every task starts and ends 1 time unit after a rising edge.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int b_delay,
                             output logic [1:0] resp);
        int  t, lat;
        bit  aw_done, w_done, aw_fire, w_fire, stable;
        logic [1:0] resp0;
        resp = 2'b11;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        WVALID = 1'b1; AWVALID = 1'b0;
        aw_done = 0; w_done = 0; t = 0; aw_wait_ok = 1;
        while (!(aw_done && w_done) && t < 40) begin
            if (!aw_done && t >= aw_delay) AWVALID = 1'b1;
            if (!aw_done && !AWVALID) aw_wait_ok &= AWREADY;
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK); #1; t++;
            if (aw_fire) begin AWVALID = 1'b0; aw_done = 1; end
            if (w_fire)  begin WVALID  = 1'b0; w_done  = 1; end
        end
        if (!(aw_done && w_done)) begin
            check("aw_w_timeout", 64'(aw_done && w_done), 64'h1);
            AWVALID = 1'b0; WVALID = 1'b0;
            return;
        end
        lat = 0;
        while (!BVALID && lat < 20) begin
            @(posedge ACLK); #1; lat++;
        end
        check("b_latency", 64'(lat), 64'd1);
        if (!BVALID) return;
        last_reg_o = reg_o;
        resp0 = BRESP;
        stable = !AWREADY && !WREADY;
        repeat (b_delay) begin
            @(posedge ACLK); #1;
            stable &= BVALID && (BRESP == resp0) && !AWREADY && !WREADY;
        end
        check("b_hold", 64'(stable), 64'h1);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        check("b_drop", 64'(BVALID), 64'h0);
        resp = resp0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_delay,
                            output logic [31:0] data, output logic [1:0] resp);
        int t;
        bit ar_fire, stable;
        data = 'x; resp = 2'b11;
        ARADDR = addr; ARVALID = 1'b1;
        ar_fire = 0; t = 0;
        while (!ar_fire && t < 40) begin
            ar_fire = ARREADY;
            @(posedge ACLK); #1; t++;
        end
        ARVALID = 1'b0;
        if (!ar_fire) begin
            check("ar_timeout", 64'(ar_fire), 64'h1);
            return;
        end
        check("r_latency", 64'(RVALID), 64'h1);
        data = RDATA; resp = RRESP;
        stable = 1;
        repeat (r_delay) begin
            @(posedge ACLK); #1;
            stable &= RVALID && (RDATA == data) && (RRESP == resp);
        end
        if (r_delay > 0) check("r_hold", 64'(stable), 64'h1);
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        check("r_drop", 64'(RVALID), 64'h0);
        check("ar_bubble", 64'(ARREADY), 64'h0);
    endtask

    logic [1:0]  resp, rresp;
    logic [31:0] rdata;
    bit          bv_seen;
    int          wait_n;

    initial begin
        logic [31:0] exp_vals [4];
        exp_vals = '{32'h1, 32'h2, 32'h3, 32'h4};
        ARESETN = 1'b0;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0;
        AWVALID = 0; WVALID = 0; BREADY = 0; ARVALID = 0; RREADY = 0;
        WDATA = '0; WSTRB = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_ready", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 64'h0);
        check("rst_regs", 64'(reg_o[63:0] | reg_o[127:64]), 64'h0);
        check("rst_outs", 64'({wr_pulse_o, BRESP, RRESP, RDATA}), 64'h0);
        ARESETN = 1'b1;
        check("ready_before_edge", 64'(AWREADY), 64'h0);
        @(posedge ACLK); #1;
        check("ready_after_edge", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // Sequential writes then reads of every register
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(4'(1 << i));
            axi_write(6'(i * 4), exp_vals[i], 4'hF, 0, 0, resp);
            check("seq_bresp", 64'(resp), 64'h0);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), 0, rdata, rresp);
            check("seq_rdata", 64'(rdata), 64'(exp_vals[i]));
            check("seq_rresp", 64'(rresp), 64'h0);
        end

        // W two cycles ahead of AW
        exp_q.push_back(4'b0100);
        axi_write(6'h08, 32'hDEADBEEF, 4'hF, 2, 0, resp);
        check("wfirst_awready", 64'(aw_wait_ok), 64'h1);
        check("wfirst_reg2", 64'(last_reg_o[95:64]), 64'hDEADBEEF);
        check("wfirst_bresp", 64'(resp), 64'h0);

        // Partial byte strobes
        exp_q.push_back(4'b0001);
        axi_write(6'h00, 32'h11223344, 4'hF, 0, 0, resp);
        exp_q.push_back(4'b0001);
        axi_write(6'h00, 32'hAABBCCDD, 4'b0101, 0, 0, resp);
        axi_read(6'h00, 0, rdata, rresp);
        check("strb_rdata", 64'(rdata), 64'h11BB33DD);

        // Back-pressure on B and R
        exp_q.push_back(4'b0010);
        axi_write(6'h04, 32'h12345678, 4'hF, 0, 10, resp);
        check("bp_bresp", 64'(resp), 64'h0);
        axi_read(6'h04, 10, rdata, rresp);
        check("bp_rdata", 64'(rdata), 64'h12345678);

        // Unaligned read maps to containing word
        axi_read(6'h0B, 0, rdata, rresp);
        check("unaligned_rdata", 64'(rdata), 64'hDEADBEEF);

        // AR handshake on the commit edge sees the old value
        exp_q.push_back(4'b1000);
        fork
            axi_write(6'h0C, 32'h77, 4'hF, 0, 0, resp);
            begin
                wait_n = 0;
                while (wr_state_o != WR_COMMIT && wait_n < 20) begin
                    @(posedge ACLK); #1; wait_n++;
                end
                check("commit_seen", 64'(wr_state_o == WR_COMMIT), 64'h1);
                axi_read(6'h0C, 0, rdata, rresp);
            end
        join
        check("collide_old", 64'(rdata), 64'h4);
        axi_read(6'h0C, 0, rdata, rresp);
        check("collide_new", 64'(rdata), 64'h77);

        // WSTRB=0: OKAY, pulse, no change
        exp_q.push_back(4'b1000);
        axi_write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, 0, resp);
        check("strb0_bresp", 64'(resp), 64'h0);
        axi_read(6'h0C, 0, rdata, rresp);
        check("strb0_rdata", 64'(rdata), 64'h77);

        // Out-of-range write and read
        axi_write(6'h20, 32'h5A, 4'hF, 0, 0, resp);
        check("oor_bresp", 64'(resp), 64'(EXP_OOR));
        axi_read(6'h20, 0, rdata, rresp);
        check("oor_rresp", 64'(rresp), 64'(EXP_OOR));
        check("oor_rdata", 64'(rdata), 64'h0);
        check("oor_regs_lo", reg_o[63:0], 64'h12345678_11BB33DD);
        check("oor_regs_hi", reg_o[127:64], 64'h00000077_DEADBEEF);

        // Reset while holding an address
        AWADDR = 6'h04; AWVALID = 1'b1;
        wait_n = 0;
        while (!AWREADY && wait_n < 20) begin
            @(posedge ACLK); #1; wait_n++;
        end
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        check("state_have_aw", 64'(wr_state_o), 64'(WR_HAVE_AW));
        ARESETN = 1'b0;
        #1;
        check("mid_rst_ready", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID}), 64'h0);
        check("mid_rst_regs", 64'(reg_o[63:0] | reg_o[127:64]), 64'h0);
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        bv_seen = 0;
        repeat (6) begin
            @(posedge ACLK); #1;
            bv_seen |= BVALID;
        end
        check("no_stale_b", 64'(bv_seen), 64'h0);
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), 0, rdata, rresp);
            check("post_rst_rdata", 64'(rdata), 64'h0);
        end
        exp_q.push_back(4'b0010);
        axi_write(6'h04, 32'hCAFE, 4'hF, 0, 0, resp);
        check("post_rst_bresp", 64'(resp), 64'h0);
        axi_read(6'h04, 0, rdata, rresp);
        check("post_rst_rdata1", 64'(rdata), 64'hCAFE);

        repeat (3) @(posedge ACLK);
        #2;
        check("pulse_pending", 64'(exp_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
